// File: rtl/pacman_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pacman_pkg
// Description : Shared game-state encoding and timing constants for the
//               game sequencer and its score accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
package pacman_pkg;

  // Encoded game state, exported on the sequencer's state port
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INIT      = 3'd1,
    ST_READY     = 3'd2,
    ST_PLAY      = 3'd3,
    ST_DYING     = 3'd4,
    ST_CLEAR     = 3'd5,
    ST_GAME_OVER = 3'd6
  } game_state_t;

  // Frame pulses between maze-flash toggles while the level is cleared
  localparam int FLASH_PERIOD = 15;

  // Convert a 0..99 integer to two packed BCD digits
  function automatic logic [7:0] to_bcd8(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/score_accum.sv
`default_nettype none
// ============================================================================
// Module      : score_accum
// Description : Saturating score adder. Adds POINTS to the current score.
//               With SCORE_BCD_EN defined the score is four packed BCD
//               digits saturating at 16'h9999; otherwise it is unsigned
//               binary saturating at 16'hFFFF.
// Revision    : 1.0 - initial release
// ============================================================================
module score_accum
  import pacman_pkg::*;
#(
  parameter int POINTS = 10
) (
  input  logic [15:0] score_i,
  output logic [15:0] sum_o
);

`ifdef SCORE_BCD_EN
  localparam logic [15:0] ADDEND = {8'h00, to_bcd8(POINTS)};

  logic [15:0] w_bcd_sum;
  logic [4:0]  w_carry;

  assign w_carry[0] = 1'b0;

  // Ripple decimal adder, one nibble per digit
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      logic [4:0] w_raw;
      assign w_raw = {1'b0, score_i[4*gi +: 4]} + {1'b0, ADDEND[4*gi +: 4]}
                   + {4'b0000, w_carry[gi]};
      assign w_carry[gi+1]        = (w_raw > 5'd9);
      assign w_bcd_sum[4*gi +: 4] = (w_raw > 5'd9) ? 4'(w_raw - 5'd10) : w_raw[3:0];
    end
  endgenerate

  // A carry out of the top digit means the score passed 9999
  assign sum_o = w_carry[4] ? 16'h9999 : w_bcd_sum;
`else
  logic [16:0] w_raw;

  assign w_raw = {1'b0, score_i} + 17'(POINTS);
  // Clamp instead of wrapping past 16'hFFFF
  assign sum_o = w_raw[16] ? 16'hFFFF : w_raw[15:0];
`endif

endmodule
`default_nettype wire

// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : game_sequencer
// Description : Top-level game flow controller: start detection, level
//               ready/death/clear timing, lives, level and score keeping.
//               Optional macro SCORE_BCD_EN selects a BCD score.
// Revision    : 1.0 - initial release
// ============================================================================
module game_sequencer
  import pacman_pkg::*;
#(
  parameter int READY_FRAMES  = 120,
  parameter int DEATH_FRAMES  = 90,
  parameter int CLEAR_FRAMES  = 120,
  parameter int START_LIVES   = 3,
  parameter int PELLET_POINTS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_clk,
  input  logic        start_btn,
  input  logic        pellet_collected,
  input  logic        all_pellets_cleared,
  input  logic        pacman_hit,
  output logic        pellet_reset,
  output logic        entity_reset,
  output logic        play_en,
  output logic [2:0]  state,
  output logic [15:0] score,
  output logic [1:0]  lives,
  output logic [3:0]  level,
  output logic        flash
);

  localparam logic [7:0] READY_LIM  = 8'(READY_FRAMES);
  localparam logic [7:0] DEATH_LIM  = 8'(DEATH_FRAMES);
  localparam logic [7:0] CLEAR_LIM  = 8'(CLEAR_FRAMES);
  localparam logic [1:0] LIVES_INIT = 2'(START_LIVES);
  localparam logic [3:0] FLASH_LAST = 4'(FLASH_PERIOD - 1);

  game_state_t state_q;
  logic [7:0]  timer_q;
  logic [3:0]  flash_cnt_q;
  logic        start_q;
  logic [15:0] score_q;
  logic [1:0]  lives_q;
  logic [3:0]  level_q;
  logic        play_en_q;
  logic        flash_q;
  logic        pellet_reset_q;
  logic        entity_reset_q;

  logic [7:0]  timer_d;
  logic [15:0] score_d;
  logic        start_edge;

  assign timer_d    = timer_q + 8'd1;
  assign start_edge = start_btn & ~start_q;

  score_accum #(
    .POINTS (PELLET_POINTS)
  ) u_score_accum (
    .score_i (score_q),
    .sum_o   (score_d)
  );

  // Game flow state machine; every output is registered here
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      timer_q        <= 8'd0;
      flash_cnt_q    <= 4'd0;
      start_q        <= 1'b0;
      score_q        <= 16'd0;
      lives_q        <= 2'd0;
      level_q        <= 4'd0;
      play_en_q      <= 1'b0;
      flash_q        <= 1'b0;
      pellet_reset_q <= 1'b0;
      entity_reset_q <= 1'b0;
    end else begin
      start_q        <= start_btn;
      // Reset pulses last one cycle unless re-armed below
      pellet_reset_q <= 1'b0;
      entity_reset_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_GAME_OVER: begin
          if (start_edge) begin
            score_q        <= 16'd0;
            lives_q        <= LIVES_INIT;
            level_q        <= 4'd1;
            pellet_reset_q <= 1'b1;
            entity_reset_q <= 1'b1;
            state_q        <= ST_INIT;
          end
        end
        ST_INIT: begin
          timer_q <= 8'd0;
          state_q <= ST_READY;
        end
        ST_READY: begin
          if (frame_clk) begin
            if (timer_d == READY_LIM) begin
              timer_q   <= 8'd0;
              play_en_q <= 1'b1;
              state_q   <= ST_PLAY;
            end else begin
              timer_q <= timer_d;
            end
          end
        end
        ST_PLAY: begin
          // Clearing the maze outranks a same-cycle collision
          if (all_pellets_cleared) begin
            score_q     <= score_d;
            play_en_q   <= 1'b0;
            timer_q     <= 8'd0;
            flash_cnt_q <= 4'd0;
            flash_q     <= 1'b0;
            state_q     <= ST_CLEAR;
          end else if (pacman_hit) begin
            play_en_q <= 1'b0;
            timer_q   <= 8'd0;
            state_q   <= ST_DYING;
          end else if (frame_clk && pellet_collected) begin
            score_q <= score_d;
          end
        end
        ST_DYING: begin
          if (frame_clk) begin
            if (timer_d == DEATH_LIM) begin
              timer_q <= 8'd0;
              if (lives_q == 2'd1) begin
                lives_q <= 2'd0;
                state_q <= ST_GAME_OVER;
              end else begin
                // Respawn only; the pellet field is kept as-is
                lives_q        <= lives_q - 2'd1;
                entity_reset_q <= 1'b1;
                state_q        <= ST_READY;
              end
            end else begin
              timer_q <= timer_d;
            end
          end
        end
        ST_CLEAR: begin
          if (frame_clk) begin
            if (timer_d == CLEAR_LIM) begin
              timer_q        <= 8'd0;
              flash_cnt_q    <= 4'd0;
              flash_q        <= 1'b0;
              level_q        <= (level_q == 4'hF) ? 4'hF : level_q + 4'd1;
              pellet_reset_q <= 1'b1;
              entity_reset_q <= 1'b1;
              state_q        <= ST_INIT;
            end else begin
              timer_q <= timer_d;
              if (flash_cnt_q == FLASH_LAST) begin
                flash_cnt_q <= 4'd0;
                flash_q     <= ~flash_q;
              end else begin
                flash_cnt_q <= flash_cnt_q + 4'd1;
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign state        = state_q;
  assign score        = score_q;
  assign lives        = lives_q;
  assign level        = level_q;
  assign play_en      = play_en_q;
  assign flash        = flash_q;
  assign pellet_reset = pellet_reset_q;
  assign entity_reset = entity_reset_q;

endmodule
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_sequencer
// Description : Directed self-checking bench for game_sequencer. Honours
//               SCORE_BCD_EN for the expected score values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_sequencer;
  import pacman_pkg::*;

  logic        clk = 1'b0;
  logic        reset, frame_clk, start_btn, pellet_collected;
  logic        all_pellets_cleared, pacman_hit;
  logic        pellet_reset, entity_reset, play_en, flash;
  logic [2:0]  state;
  logic [15:0] score;
  logic [1:0]  lives;
  logic [3:0]  level;

  int checks   = 0;
  int failures = 0;

`ifdef SCORE_BCD_EN
  localparam logic [15:0] EXP_50   = 16'h0050;
  localparam logic [15:0] EXP_60   = 16'h0060;
  localparam logic [15:0] EXP_NEAR = 16'h9990;
  localparam logic [15:0] EXP_MAX  = 16'h9999;
  localparam int          NEAR_N   = 999;
`else
  localparam logic [15:0] EXP_50   = 16'h0032;
  localparam logic [15:0] EXP_60   = 16'h003C;
  localparam logic [15:0] EXP_NEAR = 16'hFFFA;
  localparam logic [15:0] EXP_MAX  = 16'hFFFF;
  localparam int          NEAR_N   = 6553;
`endif

  game_sequencer #(
    .READY_FRAMES  (4),
    .DEATH_FRAMES  (3),
    .CLEAR_FRAMES  (32),
    .START_LIVES   (3),
    .PELLET_POINTS (10)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .frame_clk           (frame_clk),
    .start_btn           (start_btn),
    .pellet_collected    (pellet_collected),
    .all_pellets_cleared (all_pellets_cleared),
    .pacman_hit          (pacman_hit),
    .pellet_reset        (pellet_reset),
    .entity_reset        (entity_reset),
    .play_en             (play_en),
    .state               (state),
    .score               (score),
    .lives               (lives),
    .level               (level),
    .flash               (flash)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      frame_clk = 1'b1;
      tick();
      frame_clk = 1'b0;
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, 16'(state), 16'(ST_IDLE));
    check({tag, "_score"}, score, 16'h0000);
    check({tag, "_lives"}, 16'(lives), 16'd0);
    check({tag, "_level"}, 16'(level), 16'd0);
    check({tag, "_flags"}, 16'({play_en, flash, pellet_reset, entity_reset}), 16'd0);
  endtask

  initial begin
    reset = 1'b1; frame_clk = 1'b0; start_btn = 1'b0; pellet_collected = 1'b0;
    all_pellets_cleared = 1'b0; pacman_hit = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check_all_zero("rst");

    // No start edge: stay idle
    tick(); tick(); tick();
    check("idle_hold", 16'(state), 16'(ST_IDLE));

    // Start edge -> single INIT cycle with both re-init pulses
    start_btn = 1'b1;
    tick();
    check("init_state", 16'(state), 16'(ST_INIT));
    check("init_resets", 16'({pellet_reset, entity_reset}), 16'b11);
    check("init_lives", 16'(lives), 16'd3);
    check("init_level", 16'(level), 16'd1);
    tick();
    check("ready_state", 16'(state), 16'(ST_READY));
    check("ready_resets", 16'({pellet_reset, entity_reset}), 16'b00);
    frames(3);
    check("ready_3f", 16'(state), 16'(ST_READY));
    check("ready_play_en", 16'(play_en), 16'd0);
    frames(1);
    check("play_state", 16'(state), 16'(ST_PLAY));
    check("play_en", 16'(play_en), 16'd1);
    check("play_score0", score, 16'h0000);

    // Pellets only score on frame pulses
    pellet_collected = 1'b1;
    tick();
    check("pellet_noframe", score, 16'h0000);
    frames(5);
    check("score_50", score, EXP_50);
    pellet_collected = 1'b0;

    // Clear and hit together: clear wins, final pellet scored
    all_pellets_cleared = 1'b1; pacman_hit = 1'b1;
    tick();
    all_pellets_cleared = 1'b0; pacman_hit = 1'b0;
    check("clear_state", 16'(state), 16'(ST_CLEAR));
    check("clear_score", score, EXP_60);
    check("clear_play_en", 16'(play_en), 16'd0);
    check("clear_flash0", 16'(flash), 16'd0);
    frames(14);
    check("flash_14", 16'(flash), 16'd0);
    frames(1);
    check("flash_15", 16'(flash), 16'd1);
    frames(15);
    check("flash_30", 16'(flash), 16'd0);
    frames(1);
    check("clear_31", 16'(state), 16'(ST_CLEAR));
    frames(1);
    check("clear_exit", 16'(state), 16'(ST_INIT));
    check("clear_level", 16'(level), 16'd2);
    check("clear_resets", 16'({pellet_reset, entity_reset}), 16'b11);
    check("clear_flash_off", 16'(flash), 16'd0);
    tick();
    check("lvl2_ready", 16'(state), 16'(ST_READY));
    frames(4);
    check("lvl2_play", 16'(state), 16'(ST_PLAY));

    // Two non-fatal deaths
    for (int exp_lives = 2; exp_lives >= 1; exp_lives--) begin
      pacman_hit = 1'b1;
      tick();
      pacman_hit = 1'b0;
      check("dying_state", 16'(state), 16'(ST_DYING));
      frames(2);
      check("dying_hold", 16'(state), 16'(ST_DYING));
      frames(1);
      check("respawn_state", 16'(state), 16'(ST_READY));
      check("respawn_lives", 16'(lives), 16'(exp_lives));
      check("respawn_resets", 16'({pellet_reset, entity_reset}), 16'b01);
      tick();
      check("respawn_pulse_end", 16'(entity_reset), 16'd0);
      frames(4);
      check("respawn_play", 16'(state), 16'(ST_PLAY));
    end

    // Final death -> game over
    pacman_hit = 1'b1;
    tick();
    pacman_hit = 1'b0;
    frames(3);
    check("gameover_state", 16'(state), 16'(ST_GAME_OVER));
    check("gameover_lives", 16'(lives), 16'd0);
    check("gameover_ereset", 16'(entity_reset), 16'd0);
    check("gameover_score", score, EXP_60);

    // Held button must not restart; a fresh press does
    tick(); tick(); tick();
    check("held_no_restart", 16'(state), 16'(ST_GAME_OVER));
    start_btn = 1'b0;
    tick();
    start_btn = 1'b1;
    tick();
    check("restart_state", 16'(state), 16'(ST_INIT));
    check("restart_score", score, 16'h0000);
    check("restart_lives", 16'(lives), 16'd3);
    check("restart_level", 16'(level), 16'd1);
    tick();
    frames(4);
    check("restart_play", 16'(state), 16'(ST_PLAY));

    // Drive the score to just below saturation, then past it
    pellet_collected = 1'b1; frame_clk = 1'b1;
    repeat (NEAR_N) tick();
    check("score_near", score, EXP_NEAR);
    tick();
    check("score_sat", score, EXP_MAX);
    tick();
    check("score_sat_hold", score, EXP_MAX);
    pellet_collected = 1'b0; frame_clk = 1'b0;

    // Reset in the middle of DYING
    pacman_hit = 1'b1;
    tick();
    pacman_hit = 1'b0;
    frames(1);
    check("pre_reset_dying", 16'(state), 16'(ST_DYING));
    start_btn = 1'b0;
    reset = 1'b1;
    tick();
    check_all_zero("mid_rst");
    reset = 1'b0;
    tick(); tick();
    check("post_rst_idle", 16'(state), 16'(ST_IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
